// File: rtl/dds_param_sequencer.sv
// dds_param_sequencer
// Configuration controller for one PWM/DDS waveform channel. Host writes land in shadow
// registers; a commit arms the block, and the shadows are applied atomically on the next
// generator period boundary (wrap). An optional sweep then walks the active step word from
// step_start toward step_stop, one increment every `dwell` periods.
//
// Ports:
//   clk, reset        - system clock (rising edge), asynchronous active-low reset
//   cfg_valid/ready   - host write handshake; ready is low only while armed
//   cfg_addr/cfg_data - register select (0 duty .. 6 control, 7 commit) and LSB-aligned data
//   wrap              - one-cycle period-boundary pulse from the generator
//   duty_out, phase_out, step_out - active parameters driven to the generator
//   busy              - high while armed or sweeping
//   sweep_done        - one-cycle pulse when a non-looping sweep finishes
module dds_param_sequencer #(
    parameter int unsigned STEP_W  = 23,
    parameter int unsigned PHASE_W = 7,
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [2:0]         cfg_addr,
    input  logic [STEP_W-1:0]  cfg_data,
    input  logic               wrap,
    output logic [PHASE_W-1:0] duty_out,
    output logic [PHASE_W-1:0] phase_out,
    output logic [STEP_W-1:0]  step_out,
    output logic               busy,
    output logic               sweep_done
);

    typedef enum logic [1:0] {StIdle, StArmed, StRun, StSweep} state_t;

    state_t state_q, state_d;

    // Shadow registers written by the host
    logic [PHASE_W-1:0] sh_duty, sh_phase;
    logic [STEP_W-1:0]  sh_start, sh_stop, sh_inc;
    logic [DWELL_W-1:0] sh_dwell;
    logic [1:0]         sh_ctrl;

    // Sweep parameters frozen at apply so later host writes cannot disturb a running sweep
    logic [STEP_W-1:0]  act_start, act_stop, act_inc;
    logic [DWELL_W-1:0] act_dwell_m1;
    logic               act_loop;
    logic [DWELL_W-1:0] dwell_cnt;

    logic               wr_en, commit, apply, sweep_wrap, sweep_start, dwell_hit;
    logic               next_fits, sweep_end;
    logic [STEP_W:0]    step_next;
    logic [DWELL_W-1:0] sh_dwell_m1;

    assign wr_en       = cfg_valid & cfg_ready;
    assign commit      = wr_en && (cfg_addr == 3'd7);
    assign apply       = (state_q == StArmed) && wrap;
    assign sweep_wrap  = (state_q == StSweep) && wrap;
    assign sweep_start = sh_ctrl[0] && (sh_start < sh_stop);
    // A dwell of zero behaves as one period per step
    assign sh_dwell_m1 = (sh_dwell == '0) ? '0 : sh_dwell - DWELL_W'(1);
    assign dwell_hit   = (dwell_cnt == act_dwell_m1);
    // One extra bit so an increment past the top of the step range still compares correctly
    assign step_next   = {1'b0, step_out} + {1'b0, act_inc};
    assign next_fits   = step_next <= {1'b0, act_stop};
    assign sweep_end   = sweep_wrap && dwell_hit && !next_fits && !act_loop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b1;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: ;
            StArmed: begin
                cfg_ready = 1'b0;
                busy      = 1'b1;
                if (wrap) begin
                    state_d = sweep_start ? StSweep : StRun;
                end
            end
            StRun: ;
            StSweep: begin
                busy = 1'b1;
                if (sweep_end) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
        // Commit wins over a same-cycle sweep end; the wrap itself is still consumed above
        if (commit) begin
            state_d = StArmed;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_duty      <= PHASE_W'(64);
            sh_phase     <= '0;
            sh_start     <= '0;
            sh_stop      <= '0;
            sh_inc       <= '0;
            sh_dwell     <= DWELL_W'(1);
            sh_ctrl      <= '0;
            act_start    <= '0;
            act_stop     <= '0;
            act_inc      <= '0;
            act_dwell_m1 <= '0;
            act_loop     <= 1'b0;
            dwell_cnt    <= '0;
            duty_out     <= PHASE_W'(64);
            phase_out    <= '0;
            step_out     <= '0;
            sweep_done   <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (wr_en) begin
                unique case (cfg_addr)
                    3'd0: sh_duty  <= cfg_data[PHASE_W-1:0];
                    3'd1: sh_phase <= cfg_data[PHASE_W-1:0];
                    3'd2: sh_start <= cfg_data;
                    3'd3: sh_stop  <= cfg_data;
                    3'd4: sh_inc   <= cfg_data;
                    3'd5: sh_dwell <= cfg_data[DWELL_W-1:0];
                    3'd6: sh_ctrl  <= cfg_data[1:0];
                    3'd7: ;
                    default: ;
                endcase
            end
            if (apply) begin
                duty_out     <= sh_duty;
                phase_out    <= sh_phase;
                step_out     <= sh_start;
                act_start    <= sh_start;
                act_stop     <= sh_stop;
                act_inc      <= sh_inc;
                act_dwell_m1 <= sh_dwell_m1;
                act_loop     <= sh_ctrl[1];
                dwell_cnt    <= '0;
                // Sweep requested but nothing to sweep: finish immediately
                sweep_done   <= sh_ctrl[0] && !sweep_start;
            end else if (sweep_wrap) begin
                if (dwell_hit) begin
                    dwell_cnt <= '0;
                    if (next_fits) begin
                        step_out <= step_next[STEP_W-1:0];
                    end else if (act_loop) begin
                        step_out <= act_start;
                    end else begin
                        step_out   <= act_stop;
                        sweep_done <= !commit;
                    end
                end else begin
                    dwell_cnt <= dwell_cnt + DWELL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dds_param_sequencer.sv
// Bench for dds_param_sequencer: directed scenarios followed by randomized host traffic and
// wrap pulses, checked every cycle against a transaction-level model. The model describes a
// sweep in closed form (value = start + (wraps / dwell) * inc, with wrap-around or clamping).
module tb_dds_param_sequencer;
    localparam int unsigned STEP_W  = 23;
    localparam int unsigned PHASE_W = 7;
    localparam int unsigned DWELL_W = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [2:0]         cfg_addr = '0;
    logic [STEP_W-1:0]  cfg_data = '0;
    logic               wrap = 1'b0;
    logic [PHASE_W-1:0] duty_out;
    logic [PHASE_W-1:0] phase_out;
    logic [STEP_W-1:0]  step_out;
    logic               busy;
    logic               sweep_done;

    dds_param_sequencer #(
        .STEP_W (STEP_W),
        .PHASE_W(PHASE_W),
        .DWELL_W(DWELL_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .wrap      (wrap),
        .duty_out  (duty_out),
        .phase_out (phase_out),
        .step_out  (step_out),
        .busy      (busy),
        .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint s_duty, s_phase, s_start, s_stop, s_inc, s_dwell, s_ctrl;
    longint a_start, a_stop, a_inc, a_dwell;
    bit     a_loop;
    longint m_w;            // wraps seen since the sweep was applied
    bit     m_armed, m_sweep;
    longint e_duty, e_phase, e_step;
    bit     e_done;

    task automatic model_reset();
        s_duty = 64; s_phase = 0; s_start = 0; s_stop = 0; s_inc = 0; s_dwell = 1; s_ctrl = 0;
        a_start = 0; a_stop = 0; a_inc = 0; a_dwell = 1; a_loop = 0; m_w = 0;
        m_armed = 0; m_sweep = 0;
        e_duty = 64; e_phase = 0; e_step = 0; e_done = 0;
    endtask

    task automatic model_edge(input bit v, input int addr, input longint data, input bit wr);
        bit     commit, write;
        longint steps, nmax;
        commit = v && !m_armed && (addr == 7);
        write  = v && !m_armed && (addr < 7);
        e_done = 0;
        if (write) begin
            case (addr)
                0: s_duty  = data % 128;
                1: s_phase = data % 128;
                2: s_start = data;
                3: s_stop  = data;
                4: s_inc   = data;
                5: s_dwell = data % 65536;
                6: s_ctrl  = data % 4;
                default: ;
            endcase
        end
        if (m_armed && wr) begin
            e_duty = s_duty; e_phase = s_phase; e_step = s_start;
            a_start = s_start; a_stop = s_stop; a_inc = s_inc;
            a_dwell = (s_dwell == 0) ? 1 : s_dwell;
            a_loop = s_ctrl[1];
            m_w = 0;
            m_armed = 0;
            if (s_ctrl[0] && s_start < s_stop) m_sweep = 1;
            else begin
                m_sweep = 0;
                e_done = s_ctrl[0];
            end
        end else if (m_sweep && wr) begin
            m_w++;
            steps = m_w / a_dwell;
            if (a_inc != 0) begin
                nmax = (a_stop - a_start) / a_inc;
                if (a_loop) e_step = a_start + (steps % (nmax + 1)) * a_inc;
                else if (steps <= nmax) e_step = a_start + steps * a_inc;
                else begin
                    e_step = a_stop;
                    e_done = !commit;
                    m_sweep = 0;
                end
            end
        end
        if (commit) begin
            m_armed = 1;
            m_sweep = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".duty"}, 64'(duty_out), e_duty);
        check_eq({tag, ".phase"}, 64'(phase_out), e_phase);
        check_eq({tag, ".step"}, 64'(step_out), e_step);
        check_eq({tag, ".done"}, 64'(sweep_done), 64'(e_done));
        check_eq({tag, ".busy"}, 64'(busy), 64'(m_armed | m_sweep));
        check_eq({tag, ".ready"}, 64'(cfg_ready), 64'(!m_armed));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check at the falling edge
    task automatic cycle(input bit v, input int addr, input longint data, input bit wr);
        cfg_valid = v;
        cfg_addr  = addr[2:0];
        cfg_data  = data[STEP_W-1:0];
        wrap      = wr;
        @(posedge clk);
        model_edge(v, addr, data, wr);
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic wr_reg(input int addr, input longint data);
        cycle(1'b1, addr, data, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 0, 0, 1'b0);
    endtask

    int done_cnt;

    // Pulse wrap then idle; counts sweep_done pulses seen on the cycle after each wrap
    task automatic wraps(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 0, 0, 1'b1);
            if (sweep_done) done_cnt++;
            idle();
        end
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;
        idle();

        // Basic apply on wrap
        wr_reg(0, 20); wr_reg(1, 5); wr_reg(2, 1000); wr_reg(7, 0);
        idle(); idle();
        check_eq("armed.ready", 64'(cfg_ready), 64'(0));
        check_eq("armed.duty_hold", 64'(duty_out), 64'(64));
        cycle(1'b0, 0, 0, 1'b1);
        check_eq("apply.duty", 64'(duty_out), 64'(20));
        check_eq("apply.phase", 64'(phase_out), 64'(5));
        check_eq("apply.step", 64'(step_out), 64'(1000));
        check_eq("apply.busy", 64'(busy), 64'(0));

        // Non-looping sweep 100..130 by 10, dwell 2
        wr_reg(2, 100); wr_reg(3, 130); wr_reg(4, 10); wr_reg(5, 2); wr_reg(6, 1); wr_reg(7, 0);
        done_cnt = 0;
        wraps(1);
        check_eq("sweep.start", 64'(step_out), 64'(100));
        wraps(2);
        check_eq("sweep.second", 64'(step_out), 64'(110));
        wraps(8);
        check_eq("sweep.final", 64'(step_out), 64'(130));
        check_eq("sweep.done_cnt", 64'(done_cnt), 64'(1));
        check_eq("sweep.busy_end", 64'(busy), 64'(0));

        // Looping sweep, stop 125
        wr_reg(3, 125); wr_reg(6, 3); wr_reg(7, 0);
        done_cnt = 0;
        wraps(7);
        check_eq("loop.wrapped", 64'(step_out), 64'(100));
        wraps(6);
        check_eq("loop.no_done", 64'(done_cnt), 64'(0));

        // Commit coincident with a sweep wrap
        wr_reg(2, 200); wr_reg(3, 260); wr_reg(4, 20); wr_reg(5, 1); wr_reg(6, 1);
        cycle(1'b1, 7, 0, 1'b1);
        check_eq("cw.busy", 64'(busy), 64'(1));
        check_eq("cw.no_done", 64'(sweep_done), 64'(0));
        done_cnt = 0;
        wraps(1);
        check_eq("cw.apply", 64'(step_out), 64'(200));
        wr_reg(2, 50); wr_reg(3, 50);
        cycle(1'b1, 7, 0, 1'b1);
        cycle(1'b0, 0, 0, 1'b1);
        check_eq("eq.step", 64'(step_out), 64'(50));
        check_eq("eq.done", 64'(sweep_done), 64'(1));
        check_eq("eq.busy", 64'(busy), 64'(0));
        idle();

        // Reset while armed
        wr_reg(0, 99); wr_reg(7, 0);
        wrap = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        @(negedge clk);
        reset = 1'b1;
        wraps(2);
        check_eq("arst.lost_duty", 64'(duty_out), 64'(64));
        check_eq("arst.lost_step", 64'(step_out), 64'(0));

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int     r, addr;
            longint data;
            bit     v, wr;
            r  = int'($urandom_range(0, 99));
            v  = r < 45;
            wr = $urandom_range(0, 2) == 0;
            addr = (r < 6) ? 7 : int'($urandom_range(0, 6));
            case (addr)
                0, 1: data = longint'($urandom_range(0, 255));
                2:    data = longint'($urandom_range(0, 200));
                3:    data = longint'($urandom_range(0, 300));
                4:    data = longint'($urandom_range(0, 25));
                5:    data = longint'($urandom_range(0, 4));
                6:    data = longint'($urandom_range(0, 7));
                default: data = longint'($urandom_range(0, 1000));
            endcase
            cycle(v, addr, data, wr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_param_sequencer.md
Name: dds_param_sequencer

Overview:
Configuration controller for one PWM/DDS waveform channel. A host writes duty, phase and frequency-step parameters through a valid/ready port into shadow registers. A commit applies them atomically at the generator's next period boundary, so the output never glitches mid-period. An optional frequency sweep steps the active Step value from a start to a stop value, one increment every N periods.

Parameters:
STEP_W, 23, width of frequency step word (Step)
PHASE_W, 7, width of phase offset and duty words
DWELL_W, 16, width of dwell (periods per sweep step) register

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
cfg_valid  input  1  host write request
cfg_ready  output  1  block accepts write this cycle
cfg_addr  input  3  register select: 0 duty, 1 phase, 2 step_start, 3 step_stop, 4 step_inc, 5 dwell, 6 control, 7 commit
cfg_data  input  STEP_W  write data, LSB-aligned, upper bits ignored per register
wrap  input  1  one-cycle pulse from generator at phase-address wrap (period boundary)
duty_out  output  PHASE_W  active duty to generator
phase_out  output  PHASE_W  active phase offset to generator
step_out  output  STEP_W  active frequency step to generator
busy  output  1  high in ARMED or SWEEP
sweep_done  output  1  one-cycle pulse when a non-looping sweep ends

Behaviour:
- Reset (reset=0, async):
  - State IDLE; duty_out=64; phase_out=0; step_out=0; sweep_done=0; dwell_cnt=0.
  - Shadows: duty=64, phase=0, start=stop=inc=0, dwell=1, control=0.
  - Reset mid-sweep or mid-ARMED discards all pending state.
- Write handshake: a write occurs when cfg_valid & cfg_ready at a clk edge.
  - cfg_ready=1 in IDLE, RUN and SWEEP; cfg_ready=0 in ARMED.
  - Writes to addr 0-6 update shadows only; active outputs are unaffected.
  - control: bit0 sweep_en, bit1 sweep_loop.
  - dwell=0 is stored but treated as 1.
- Commit: a write to addr 7 (data ignored) moves the FSM from any state to ARMED.
  - A commit during SWEEP aborts the sweep; no sweep_done is generated.
- States:
  - IDLE: outputs hold; busy=0.
  - ARMED: waits for wrap. On wrap, active outputs take the shadow values one cycle later (registered; duty_out, phase_out and step_out=step_start change on the edge after wrap is sampled). dwell_cnt=0.
    - If sweep_en=1 and step_start<step_stop, go to SWEEP.
    - Otherwise go to RUN. If sweep_en=1 and step_start>=step_stop, pulse sweep_done in the same cycle.
  - RUN: outputs static; busy=0. wrap is ignored.
  - SWEEP: each wrap increments dwell_cnt. When dwell_cnt reaches dwell-1, dwell_cnt clears and next = step_out + step_inc, computed in STEP_W+1 bits.
    - If next <= step_stop: step_out=next.
    - Else if sweep_loop=1: step_out=step_start; stay in SWEEP.
    - Else: step_out=step_stop, pulse sweep_done, go to RUN.
    - step_inc=0 sweeps forever at step_start with no done.
- Simultaneous events:
  - A commit and wrap in the same cycle: the commit registers, and the wrap is consumed by the old state (RUN ignores it; SWEEP processes it as a normal sweep wrap). Parameters apply at the following wrap.
  - A shadow write and wrap in the same cycle in ARMED cannot occur, because cfg_ready=0.
  - A shadow write in SWEEP changes step_stop, step_inc and dwell for the next commit only. The running sweep uses copies latched at apply.
- Outputs change only on period boundaries (after reset). Latency from wrap to new outputs is 1 clk.

Test Plan:
- Reset release -> duty_out=64, phase_out=0, step_out=0, cfg_ready=1, busy=0.
- Write duty=20, phase=5, start=1000, commit -> outputs unchanged and cfg_ready=0 until the wrap pulse. One cycle after wrap: duty_out=20, phase_out=5, step_out=1000, state RUN.
- Sweep with start=100, stop=130, inc=10, dwell=2, sweep_en=1, loop=0 -> step_out goes 100 → 110 → 120 → 130, changing every 2nd wrap. On the step after 130, step_out stays 130 and sweep_done pulses once.
- Same sweep with loop=1, stop=125 -> step_out sequence 100, 110, 120, 100, 110…; no sweep_done.
- Commit asserted in the same cycle as wrap during SWEEP -> the sweep processes that wrap normally, and the new values apply at the next wrap with no sweep_done. Then repeat with sweep_en=1, start=50, stop=50 -> RUN, step_out=50, sweep_done pulse at apply.
- Assert reset while ARMED with a wrap pending -> all outputs return to reset values immediately and the pending commit is lost.
